// File: rtl/sn76489_sequencer_wb8_if.sv
// ----------------------------------------------------------------------------
// sn76489_sequencer_wb8_if
// 8-bit, single-address-bit Wishbone-style bus used on both sides of the
// SN76489 sequencer: the CPU command/status port and the master port toward
// the sound chip.
//   adr   : word address (0 = command/status, 1 = control on the CPU port)
//   dat_w : write data, master -> slave
//   dat_r : read data, slave -> master
//   stb   : transfer strobe, held by the master until ack
//   we    : write enable
//   ack   : transfer acknowledge from the slave
// ----------------------------------------------------------------------------
interface sn76489_sequencer_wb8_if;
  logic       adr;
  logic [7:0] dat_w;
  logic [7:0] dat_r;
  logic       stb;
  logic       we;
  logic       ack;

  modport master (output adr, dat_w, stb, we, input dat_r, ack);
  modport slave  (input adr, dat_w, stb, we, output dat_r, ack);
endinterface

// File: rtl/sn76489_sequencer_wb8.sv
// ----------------------------------------------------------------------------
// sn76489_sequencer_wb8
// The CPU pushes a byte-command stream (sound-chip register writes and timed
// waits) into a FIFO. A sequencer then replays the writes to the SN76489 with
// sample-tick delays between them, so the CPU does not need cycle-accurate timing.
//
// Ports
//   I_clk      : single clock
//   I_reset_n  : asynchronous active-low reset
//   cpu        : slave port. Writing adr 0 pushes a command byte. Writing adr 1
//                acts on bit0 = flush and bit1 = clear overflow/badop.
//                Reads return {full, empty, busy, overflow, badop, 3'b000}.
//   snd        : master port toward the sound chip. The design only writes.
//   O_busy     : the sequencer is not idle, or the FIFO holds bytes.
//
// Command bytes
//   0x50 dd    : write dd to the sound chip
//   0x61 ll hh : wait {hh,ll} ticks. A value of 0 means no wait.
//   0x7n       : wait n+1 ticks
//   other      : discarded, and the sticky badop flag is set
// ----------------------------------------------------------------------------
module sn76489_sequencer_wb8 #(
  parameter int FIFO_DEPTH  = 16,
  parameter int TICK_DIVIDE = 1134
) (
  input  logic                           I_clk,
  input  logic                           I_reset_n,
  sn76489_sequencer_wb8_if.slave         cpu,
  sn76489_sequencer_wb8_if.master        snd,
  output logic                           O_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;                 // extra wrap bit tells full from empty
  localparam int TW = $clog2(TICK_DIVIDE);

  typedef enum logic [2:0] {
    S_IDLE, S_GETDATA, S_GETLO, S_GETHI, S_WRITE, S_WAIT
  } state_t;

  // --------------------------------------------------------------------------
  // Command FIFO (first-word fall-through)
  // --------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty;
  logic [7:0]    head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // CPU bus decode
  logic cpu_wr, push_req, ctrl_wr, flush, clr_err, push, pop;
  assign cpu_wr   = cpu.stb && cpu.we;
  assign push_req = cpu_wr && !cpu.adr;
  assign ctrl_wr  = cpu_wr && cpu.adr;
  assign flush    = ctrl_wr && cpu.dat_w[0];
  assign clr_err  = ctrl_wr && cpu.dat_w[1];
  // The full flag is taken before any pop in the same cycle, so a push while
  // full is always dropped.
  assign push     = push_req && !full && !flush;

  state_t state;

  // Every state that consumes a byte pops whenever one is available. A flush
  // suppresses the pop because the pointers are being cleared anyway.
  always_comb begin
    // NOTE: assign a default before the case so that no latch is inferred.
    pop = 1'b0;
    if (!empty && !flush) begin
      case (state)
        S_IDLE, S_GETDATA, S_GETLO, S_GETHI: pop = 1'b1;
        default:                             pop = 1'b0;
      endcase
    end
  end

  // NOTE: storage is left without reset. The pointers alone define which
  // entries are valid, so the array can map onto plain RAM.
  always_ff @(posedge I_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cpu.dat_w;
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then sees pre-edge values, independent of process ordering.
    if (!I_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // CPU slave port: ack and read data are registered copies of the strobe cycle
  // --------------------------------------------------------------------------
  logic       overflow, badop;
  logic [7:0] status;
  assign status = {full, empty, O_busy, overflow, badop, 3'b000};

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      cpu.ack   <= 1'b0;
      cpu.dat_r <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      cpu.ack   <= cpu.stb;
      cpu.dat_r <= cpu.stb ? status : 8'h00;
      if (clr_err)             overflow <= 1'b0;
      else if (push_req && full) overflow <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Free-running sample tick. Commands never restart it.
  // --------------------------------------------------------------------------
  logic [TW-1:0] tick_cnt;
  logic          tick;
  assign tick = (tick_cnt == TW'(TICK_DIVIDE - 1));

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n)  tick_cnt <= '0;
    else if (tick)   tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + TW'(1);
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  logic [15:0] count;
  logic        snd_stb;
  logic [7:0]  snd_dat;

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state   <= S_IDLE;
      count   <= '0;
      snd_stb <= 1'b0;
      snd_dat <= 8'h00;
      badop   <= 1'b0;
    end else begin
      if (clr_err) badop <= 1'b0;

      // A flush abandons any pending command except a bus write in flight.
      // That write must finish its handshake before the sequencer goes idle.
      if (flush && state != S_WRITE) begin
        state <= S_IDLE;
        count <= '0;
      end else begin
        if (flush) count <= '0;
        case (state)
          S_IDLE: if (pop) begin
            if (head == 8'h50)           state <= S_GETDATA;
            else if (head == 8'h61)      state <= S_GETLO;
            else if (head[7:4] == 4'h7) begin
              count <= {12'h000, head[3:0]} + 16'd1;
              state <= S_WAIT;
            end else begin
              badop <= 1'b1;           // opcode already popped, i.e. discarded
            end
          end
          S_GETDATA: if (pop) begin
            snd_dat <= head;
            snd_stb <= 1'b1;
            state   <= S_WRITE;
          end
          S_GETLO: if (pop) begin
            count[7:0] <= head;
            state      <= S_GETHI;
          end
          S_GETHI: if (pop) begin
            count[15:8] <= head;
            state       <= ({head, count[7:0]} != 16'h0000) ? S_WAIT : S_IDLE;
          end
          S_WRITE: if (snd.ack) begin
            snd_stb <= 1'b0;
            state   <= S_IDLE;
          end
          S_WAIT: if (tick) begin
            count <= count - 16'd1;
            if (count == 16'd1) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign snd.stb   = snd_stb;
  assign snd.we    = snd_stb;
  assign snd.dat_w = snd_dat;
  assign snd.adr   = 1'b0;

  assign O_busy = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_sn76489_sequencer_wb8.sv
// ----------------------------------------------------------------------------
// Directed testbench for sn76489_sequencer_wb8 (FIFO_DEPTH=16, TICK_DIVIDE=10).
// The bench includes a sound-chip responder that acks one cycle after it sees
// stb. It also includes a monitor that records each write transaction.
// ----------------------------------------------------------------------------
module tb_sn76489_sequencer_wb8;
  localparam int FD = 16;
  localparam int TD = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic ack_en;

  always #5 clk = ~clk;

  sn76489_sequencer_wb8_if cpu_bus ();
  sn76489_sequencer_wb8_if snd_bus ();

  sn76489_sequencer_wb8 #(.FIFO_DEPTH(FD), .TICK_DIVIDE(TD)) dut (
    .I_clk     (clk),
    .I_reset_n (rst_n),
    .cpu       (cpu_bus),
    .snd       (snd_bus),
    .O_busy    (busy)
  );

  // Sound chip: acks one cycle after stb, while ack_en is set.
  assign snd_bus.dat_r = 8'h00;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) snd_bus.ack <= 1'b0;
    else        snd_bus.ack <= ack_en && snd_bus.stb && !snd_bus.ack;
  end

  // Transaction monitor. It samples the pre-edge values at each rising edge.
  int         cyc = 0, stb_cycles = 0, txn_count = 0;
  logic [7:0] txn_dat [4];
  int         ack_cyc [4];
  int         first_hi_cyc [4];
  logic       prev_stb = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (snd_bus.stb) begin
      stb_cycles++;
      if (!prev_stb && txn_count < 4) first_hi_cyc[txn_count] = cyc;
      if (snd_bus.ack) begin
        if (txn_count < 4) begin
          txn_dat[txn_count] = snd_bus.dat_w;
          ack_cyc[txn_count] = cyc;
        end
        txn_count++;
      end
    end
    prev_stb = snd_bus.stb;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every task returns 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] d);
    cpu_bus.adr   = a;
    cpu_bus.dat_w = d;
    cpu_bus.we    = 1'b1;
    cpu_bus.stb   = 1'b1;
    step(1);
    cpu_bus.stb   = 1'b0;
    cpu_bus.we    = 1'b0;
  endtask

  task automatic cpu_read(input logic a, output logic [7:0] d, output logic ack);
    cpu_bus.adr = a;
    cpu_bus.we  = 1'b0;
    cpu_bus.stb = 1'b1;
    step(1);
    cpu_bus.stb = 1'b0;
    d   = cpu_bus.dat_r;
    ack = cpu_bus.ack;
  endtask

  task automatic wait_txn(input string tag, input int n, input int budget);
    int k = 0;
    while (txn_count < n && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 32'(txn_count >= n), 32'd1);
  endtask

  logic [7:0] rd;
  logic       rack;
  int         gap;

  initial begin
    cpu_bus.adr = 1'b0; cpu_bus.dat_w = 8'h00; cpu_bus.stb = 1'b0; cpu_bus.we = 1'b0;
    ack_en = 1'b1;

    // ---- Reset state ----
    step(3);
    check("rst_snd_stb", 32'(snd_bus.stb), 32'd0);
    check("rst_snd_we",  32'(snd_bus.we),  32'd0);
    check("rst_snd_dat", 32'(snd_bus.dat_w), 32'h00);
    check("rst_wb_ack",  32'(cpu_bus.ack), 32'd0);
    check("rst_wb_dat",  32'(cpu_bus.dat_r), 32'h00);
    check("rst_busy",    32'(busy), 32'd0);
    rst_n = 1'b1;
    step(1);
    cpu_read(1'b0, rd, rack);
    check("rst_status", 32'(rd), 32'h40);
    check("rd_ack",     32'(rack), 32'd1);
    step(1);
    check("ack_drops",  32'(cpu_bus.ack), 32'd0);

    // ---- Single write 0x50 0x9F ----
    stb_cycles = 0; txn_count = 0;
    cpu_write(1'b0, 8'h50);
    cpu_write(1'b0, 8'h9F);
    wait_txn("w1_timeout", 1, 20);
    // This point is just after the ack edge. Stb and busy must already be low.
    check("w1_stb_low",  32'(snd_bus.stb), 32'd0);
    check("w1_busy_low", 32'(busy), 32'd0);
    check("w1_dat",      32'(txn_dat[0]), 32'h9F);
    check("w1_stb_cyc",  32'(stb_cycles), 32'd2);
    step(5);
    check("w1_one_txn",  32'(txn_count), 32'd1);

    // ---- Write, wait 3 ticks, write ----
    stb_cycles = 0; txn_count = 0;
    cpu_write(1'b0, 8'h50);
    cpu_write(1'b0, 8'h81);
    cpu_write(1'b0, 8'h72);
    cpu_write(1'b0, 8'h50);
    cpu_write(1'b0, 8'h0A);
    wait_txn("w2_timeout", 2, 100);
    check("w2_dat0", 32'(txn_dat[0]), 32'h81);
    check("w2_dat1", 32'(txn_dat[1]), 32'h0A);
    // The wait opcode pops 1 cycle after the ack edge. The wait lasts 21..30
    // cycles, and fetching 0x50 dd takes 2 more cycles. The second stb
    // therefore rises 24..33 edges after the first ack edge.
    gap = (first_hi_cyc[1] - 1) - ack_cyc[0];
    check("w2_gap_in_window", 32'(gap >= 24 && gap <= 33), 32'd1);
    step(2);
    check("w2_idle", 32'(busy), 32'd0);

    // ---- Overflow and flush, with the FSM parked in WRITE (no ack) ----
    ack_en = 1'b0; stb_cycles = 0; txn_count = 0;
    cpu_write(1'b0, 8'h50);
    cpu_write(1'b0, 8'h00);
    step(3);
    check("ov_stalled_stb", 32'(snd_bus.stb), 32'd1);
    for (int i = 0; i < 17; i++) cpu_write(1'b0, 8'h70);
    cpu_read(1'b0, rd, rack);
    check("ov_full_status", 32'(rd), 32'hB0);
    cpu_write(1'b1, 8'h02);
    cpu_read(1'b1, rd, rack);
    check("ov_cleared", 32'(rd), 32'hA0);
    cpu_write(1'b1, 8'h01);
    cpu_read(1'b0, rd, rack);
    check("fl_empty_busy", 32'(rd), 32'h60);
    check("fl_stb_held",   32'(snd_bus.stb), 32'd1);
    ack_en = 1'b1;
    wait_txn("fl_timeout", 1, 10);
    check("fl_dat",  32'(txn_dat[0]), 32'h00);
    check("fl_idle", 32'(busy), 32'd0);
    step(3);
    cpu_read(1'b0, rd, rack);
    check("fl_status", 32'(rd), 32'h40);
    check("fl_one_txn", 32'(txn_count), 32'd1);

    // ---- Bad opcode and zero-length wait ----
    stb_cycles = 0;
    cpu_write(1'b0, 8'h33);
    step(2);
    cpu_read(1'b0, rd, rack);
    check("bad_status", 32'(rd), 32'h48);
    check("bad_no_stb", 32'(stb_cycles), 32'd0);
    cpu_write(1'b0, 8'h61);
    cpu_write(1'b0, 8'h00);
    cpu_write(1'b0, 8'h00);
    step(2);
    check("w0_idle", 32'(busy), 32'd0);
    cpu_write(1'b1, 8'h02);
    cpu_read(1'b0, rd, rack);
    check("bad_cleared", 32'(rd), 32'h40);
    check("w0_no_stb", 32'(stb_cycles), 32'd0);

    // ---- Async reset mid-WRITE ----
    ack_en = 1'b0; txn_count = 0;
    cpu_write(1'b0, 8'h50);
    cpu_write(1'b0, 8'h55);
    begin
      int k = 0;
      while (!snd_bus.stb && k < 10) begin step(1); k++; end
    end
    check("rw_stb_up", 32'(snd_bus.stb), 32'd1);
    check("rw_dat",    32'(snd_bus.dat_w), 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_stb_async", 32'(snd_bus.stb), 32'd0);
    check("rw_we_async",  32'(snd_bus.we), 32'd0);
    check("rw_dat_async", 32'(snd_bus.dat_w), 32'h00);
    check("rw_busy",      32'(busy), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    cpu_read(1'b0, rd, rack);
    check("rw_status", 32'(rd), 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
